// File: rtl/fp_class_pkg.sv
// -----------------------------------------------------------------------------
// fp_class_pkg
// Shared definitions for the IEEE-754 operand classifier:
//   - class bit positions in the one-hot vector (RISC-V fclass ordering)
//   - NUM_CLASSES, the width of that vector
//   - fp_width(), the packed operand width {sign, exp, man}
// -----------------------------------------------------------------------------
package fp_class_pkg;

    localparam int CLS_NINF    = 0;   // -infinity
    localparam int CLS_NNORM   = 1;   // -normal
    localparam int CLS_NSUB    = 2;   // -subnormal
    localparam int CLS_NZERO   = 3;   // -0
    localparam int CLS_PZERO   = 4;   // +0
    localparam int CLS_PSUB    = 5;   // +subnormal
    localparam int CLS_PNORM   = 6;   // +normal
    localparam int CLS_PINF    = 7;   // +infinity
    localparam int CLS_SNAN    = 8;   // signalling NaN (sign ignored)
    localparam int CLS_QNAN    = 9;   // quiet NaN (sign ignored)

    localparam int NUM_CLASSES = 10;

    // Total operand width: one sign bit plus exponent and stored significand.
    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_class_decode.sv
// -----------------------------------------------------------------------------
// fp_class_decode
// Purely combinational IEEE-754 field decode into a 10-bit one-hot class
// vector. Reusable wherever an operand class is needed.
//
// Parameters:
//   EXP_W   exponent field width (>= 2)
//   MAN_W   stored significand width (>= 2)
// Ports:
//   i_data  [FP_W-1:0]         operand {sign, exp, man}
//   o_class [NUM_CLASSES-1:0]  one-hot class, exactly one bit set
// -----------------------------------------------------------------------------
module fp_class_decode
    import fp_class_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic [fp_width(EXP_W, MAN_W)-1:0] i_data,
    output logic [NUM_CLASSES-1:0]            o_class
);

    localparam int FP_W = fp_width(EXP_W, MAN_W);

    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_zero;
    logic             w_quiet;

    assign w_sign     = i_data[FP_W-1];
    assign w_exp      = i_data[MAN_W +: EXP_W];
    assign w_man      = i_data[MAN_W-1:0];
    assign w_exp_ones = &w_exp;
    assign w_exp_zero = ~|w_exp;
    assign w_man_zero = ~|w_man;
    assign w_quiet    = w_man[MAN_W-1];

    always_comb begin
        // NOTE: default assigned first so every path drives o_class and no latch is inferred.
        o_class = '0;
        if (w_exp_ones) begin
            if (w_man_zero) begin
                o_class[w_sign ? CLS_NINF : CLS_PINF] = 1'b1;
            end else if (w_quiet) begin
                // NaN classes deliberately ignore the sign bit.
                o_class[CLS_QNAN] = 1'b1;
            end else begin
                o_class[CLS_SNAN] = 1'b1;
            end
        end else if (w_exp_zero) begin
            if (w_man_zero) begin
                o_class[w_sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
            end else begin
                o_class[w_sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
            end
        end else begin
            o_class[w_sign ? CLS_NNORM : CLS_PNORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_class_pipe.sv
// -----------------------------------------------------------------------------
// fp_class_pipe
// Pipelined IEEE-754 operand classifier with valid/ready handshake and
// per-class saturating event counters for debug/coverage.
//
// Parameters:
//   EXP_W, MAN_W  operand format (half = 5/10, single = 8/23, double = 11/52)
//   CNT_W         width of each per-class event counter
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   stage can accept an operand this cycle
//   in_data    operand {sign, exp, man}
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_class  registered one-hot class vector
//   out_data   operand echoed alongside its class
//   cnt_sel    counter index for readback (0..9)
//   cnt_data   selected counter value, 0 for out-of-range index
//   cnt_clr    synchronous clear of all counters
// -----------------------------------------------------------------------------
module fp_class_pipe
    import fp_class_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [fp_width(EXP_W, MAN_W)-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CLASSES-1:0]            out_class,
    output logic [fp_width(EXP_W, MAN_W)-1:0] out_data,
    input  logic [3:0]                        cnt_sel,
    output logic [CNT_W-1:0]                  cnt_data,
    input  logic                              cnt_clr
);

    localparam int FP_W = fp_width(EXP_W, MAN_W);

    logic [NUM_CLASSES-1:0] w_class;
    logic                   w_accept;

    logic                   r_out_valid;
    logic [NUM_CLASSES-1:0] r_out_class;
    logic [FP_W-1:0]        r_out_data;
    logic [CNT_W-1:0]       r_cnt [NUM_CLASSES];

    fp_class_decode #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_decode (
        .i_data  (in_data),
        .o_class (w_class)
    );

    // Single-entry stage: a draining result frees the slot in the same cycle,
    // so continuous flow has no bubble. out_ready -> in_ready is the only
    // combinational input-to-output path.
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Handshake register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_class <= w_class;
            r_out_data  <= in_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_data  = r_out_data;

    // Per-class saturating counters. Clear has priority over counting, so an
    // operand accepted in the clear cycle is not counted.
    always_ff @(posedge clk) begin
        // NOTE: the counter array is reset explicitly; it is architectural state, not scratch storage.
        if (rst || cnt_clr) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (w_class[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Readback mux; indices 10..15 read as zero.
    always_comb begin
        cnt_data = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (cnt_sel == 4'(i)) begin
                cnt_data = r_cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_fp_class_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_class_pipe
// Self-checking bench for fp_class_pipe. Three instances:
//   u_half   default half precision, 16-bit counters (stream, backpressure, reset)
//   u_single EXP_W=8, MAN_W=23
//   u_cnt    half precision, CNT_W=2 (saturation / clear)
// Expected results are pushed to a queue at accept and popped at the
// output handshake.
// -----------------------------------------------------------------------------
module tb_fp_class_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // half-precision instance
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_cnt_clr;
    logic [15:0] h_in_data, h_out_data, h_cnt_data;
    logic [9:0]  h_out_class;
    logic [3:0]  h_cnt_sel;

    // single-precision instance
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
    logic [31:0] s_in_data, s_out_data;
    logic [15:0] s_cnt_data;
    logic [9:0]  s_out_class;
    logic [3:0]  s_cnt_sel;

    // narrow-counter instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_cnt_clr;
    logic [15:0] c_in_data, c_out_data;
    logic [1:0]  c_cnt_data;
    logic [9:0]  c_out_class;
    logic [3:0]  c_cnt_sel;

    fp_class_pipe u_half (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_class(h_out_class), .out_data(h_out_data),
        .cnt_sel(h_cnt_sel), .cnt_data(h_cnt_data), .cnt_clr(h_cnt_clr)
    );

    fp_class_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) u_single (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_class(s_out_class), .out_data(s_out_data),
        .cnt_sel(s_cnt_sel), .cnt_data(s_cnt_data), .cnt_clr(s_cnt_clr)
    );

    fp_class_pipe #(.CNT_W(2)) u_cnt (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_class(c_out_class), .out_data(c_out_data),
        .cnt_sel(c_cnt_sel), .cnt_data(c_cnt_data), .cnt_clr(c_cnt_clr)
    );

    typedef struct packed {
        logic [9:0]  cls;
        logic [31:0] data;
    } exp_t;

    exp_t q_h[$];
    exp_t q_s[$];
    int   hcnt[10];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference classifier written from the class table.
    function automatic int cls_idx(input bit s, input bit e1, input bit e0,
                                   input bit m0, input bit q);
        if (e1 && !m0) return q ? 9 : 8;
        if (e1)        return s ? 0 : 7;
        if (e0)        return m0 ? (s ? 3 : 4) : (s ? 2 : 5);
        return s ? 1 : 6;
    endfunction

    function automatic int idx_h(input logic [15:0] d);
        return cls_idx(d[15], d[14:10] == 5'h1f, d[14:10] == 5'h00,
                       d[9:0] == 10'h000, d[9]);
    endfunction

    function automatic int idx_s(input logic [31:0] d);
        return cls_idx(d[31], d[30:23] == 8'hff, d[30:23] == 8'h00,
                       d[22:0] == 23'h0, d[22]);
    endfunction

    // One cycle on u_half: drive at negedge, check at negedge+1, then clock.
    task automatic step_h(input logic v, input logic [15:0] d, input logic ordy);
        logic exp_rdy;
        exp_t e;
        int   k;
        h_in_valid  = v;
        h_in_data   = d;
        h_out_ready = ordy;
        #1;
        exp_rdy = (q_h.size() == 0) || ordy;
        n_vec++;
        if (h_in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL h_in_ready: got %b expected %b", h_in_ready, exp_rdy);
        end
        n_vec++;
        if (h_out_valid !== (q_h.size() != 0)) begin
            n_err++;
            $display("FAIL h_out_valid: got %b expected %b", h_out_valid, q_h.size() != 0);
        end
        if (q_h.size() != 0) begin
            e = q_h[0];
            n_vec++;
            if (h_out_class !== e.cls) begin
                n_err++;
                $display("FAIL h_out_class: got %h expected %h", h_out_class, e.cls);
            end
            n_vec++;
            if (h_out_data !== e.data[15:0]) begin
                n_err++;
                $display("FAIL h_out_data: got %h expected %h", h_out_data, e.data[15:0]);
            end
            if (ordy) void'(q_h.pop_front());
        end
        if (v && exp_rdy) begin
            k = idx_h(d);
            q_h.push_back('{cls: 10'(1) << k, data: {16'h0, d}});
            hcnt[k]++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_s(input logic v, input logic [31:0] d);
        exp_t e;
        s_in_valid  = v;
        s_in_data   = d;
        s_out_ready = 1'b1;
        #1;
        n_vec++;
        if (s_out_valid !== (q_s.size() != 0)) begin
            n_err++;
            $display("FAIL s_out_valid: got %b expected %b", s_out_valid, q_s.size() != 0);
        end
        if (q_s.size() != 0) begin
            e = q_s.pop_front();
            n_vec++;
            if (s_out_class !== e.cls || s_out_data !== e.data) begin
                n_err++;
                $display("FAIL s_out: got %h/%h expected %h/%h",
                         s_out_class, s_out_data, e.cls, e.data);
            end
        end
        if (v && s_in_ready) q_s.push_back('{cls: 10'(1) << idx_s(d), data: d});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cnts_h();
        for (int i = 0; i < 10; i++) begin
            h_cnt_sel = 4'(i);
            #1;
            n_vec++;
            if (h_cnt_data !== 16'(hcnt[i])) begin
                n_err++;
                $display("FAIL h_cnt[%0d]: got %0d expected %0d", i, h_cnt_data, hcnt[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic c_accept(input logic [15:0] d, input logic clr);
        c_in_valid = 1'b1;
        c_in_data  = d;
        c_cnt_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        c_in_valid = 1'b0;
        c_cnt_clr  = 1'b0;
    endtask

    task automatic c_read(input logic [3:0] sel, input logic [1:0] exp_v);
        c_cnt_sel = sel;
        #1;
        n_vec++;
        if (c_cnt_data !== exp_v) begin
            n_err++;
            $display("FAIL c_cnt[%0d]: got %0d expected %0d", sel, c_cnt_data, exp_v);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        h_in_valid = 1'b0; h_in_data = '0; h_out_ready = 1'b0; h_cnt_sel = '0; h_cnt_clr = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1; s_cnt_sel = '0; s_cnt_clr = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1; c_cnt_sel = '0; c_cnt_clr = 1'b0;
        for (int i = 0; i < 10; i++) hcnt[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (h_out_valid !== 1'b0 || h_out_class !== 10'h000 || h_out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%h/%h expected 0/000/0000",
                     h_out_valid, h_out_class, h_out_data);
        end
        n_vec++;
        if (h_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 1", h_in_ready);
        end
        @(negedge clk);
        check_cnts_h();
    endtask

    task automatic test_stream();
        logic [15:0] vec [10];
        vec = '{16'hFC00, 16'hBC00, 16'h8001, 16'h8000, 16'h0000,
                16'h0001, 16'h3C00, 16'h7C00, 16'h7C01, 16'h7E00};
        for (int i = 0; i < 10; i++) step_h(1'b1, vec[i], 1'b1);
        step_h(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_single();
        logic [31:0] vec [4];
        vec = '{32'h7F800000, 32'h7FC00000, 32'hFF800001, 32'h00400000};
        for (int i = 0; i < 4; i++) step_s(1'b1, vec[i]);
        step_s(1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        step_h(1'b1, 16'h3C00, 1'b1);
        repeat (3) step_h(1'b1, 16'h7C00, 1'b0);   // stalled: must not accept
        step_h(1'b1, 16'h7C00, 1'b1);              // drain and accept together
        step_h(1'b0, 16'h0000, 1'b1);
        step_h(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_counters();
        c_accept(16'h0000, 1'b0);
        c_read(4'd4, 2'd1);
        repeat (2) c_accept(16'h0000, 1'b0);
        c_read(4'd4, 2'd3);
        repeat (2) c_accept(16'h0000, 1'b0);
        c_read(4'd4, 2'd3);
        c_read(4'd12, 2'd0);
        c_accept(16'h3C00, 1'b0);
        c_read(4'd6, 2'd1);
        c_accept(16'h0000, 1'b1);                  // clear wins over the accept
        c_read(4'd4, 2'd0);
        c_read(4'd6, 2'd0);
        c_accept(16'h8000, 1'b0);
        c_read(4'd3, 2'd1);
        c_read(4'd4, 2'd0);
    endtask

    task automatic test_reset_mid();
        step_h(1'b1, 16'h7E00, 1'b0);
        step_h(1'b0, 16'h0000, 1'b0);
        h_in_valid = 1'b0;
        check_cnts_h();
        rst = 1'b1;
        h_in_valid = 1'b1; h_in_data = 16'h3C00; h_out_ready = 1'b1;
        c_in_valid = 1'b1; c_in_data = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        h_in_valid = 1'b0; h_out_ready = 1'b0;
        c_in_valid = 1'b0;
        q_h.delete();
        for (int i = 0; i < 10; i++) hcnt[i] = 0;
        #1;
        n_vec++;
        if (h_out_valid !== 1'b0 || h_out_class !== 10'h000 || h_out_data !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b/%h/%h expected 0/000/0000",
                     h_out_valid, h_out_class, h_out_data);
        end
        n_vec++;
        if (h_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_in_ready: got %b expected 1", h_in_ready);
        end
        @(negedge clk);
        check_cnts_h();
        for (int i = 0; i < 10; i++) c_read(4'(i), 2'd0);
        step_h(1'b0, 16'h0000, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_single();
        test_back_to_back();
        test_counters();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_class_pipe.md
# fp_class_pipe

Parametrised, pipelined IEEE-754 operand classifier for the FPU front end. It accepts one floating-point word per cycle under a valid/ready handshake and emits a registered 10-way one-hot class vector (RISC-V `fclass` ordering) together with the sign and the pass-through operand. It also keeps per-class saturating event counters for debug and coverage. It replaces the fixed half-precision combinational classifier, and serves half, single and double formats through parameters.

## Interface
- `EXP_W`, default 5: exponent field width (≥2).
- `MAN_W`, default 10: stored significand width (≥2).
- `CNT_W`, default 16: width of each per-class event counter.
- Derived width: `FP_W = 1 + EXP_W + MAN_W`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand this cycle.
- `in_data`  in  FP_W  operand, laid out as {sign, exp, man}.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_class`  out  10  one-hot class vector.
- `out_data`  out  FP_W  operand echoed alongside its class.
- `cnt_sel`  in  4  counter index for readback (0–9).
- `cnt_data`  out  CNT_W  value of counter `cnt_sel`; 0 when `cnt_sel` > 9.
- `cnt_clr`  in  1  clears all counters synchronously.

## Operation
- Field decode:
  - `exp_ones` = all EXP_W exponent bits are 1.
  - `exp_zero` = all exponent bits are 0.
  - `man_zero` = all MAN_W significand bits are 0.
  - `quiet` = significand MSB.
- Class bit positions in `out_class`:
  - 0: −inf
  - 1: −normal
  - 2: −subnormal
  - 3: −0
  - 4: +0
  - 5: +subnormal
  - 6: +normal
  - 7: +inf
  - 8: sNaN (exp_ones & ~man_zero & ~quiet)
  - 9: qNaN (exp_ones & quiet)
- NaN classes ignore the sign bit. Exactly one bit of `out_class` is set whenever `out_valid` = 1.
- Pipeline register:
  - Accept when `in_valid & in_ready`.
  - `in_ready = ~out_valid | out_ready`, a single-entry stage with no bubble under continuous flow.
  - On accept, the decoded class and the operand are loaded, and `out_valid` is set.
  - On an output handshake with no new accept, `out_valid` clears.
- While `out_valid & ~out_ready`, `out_class` and `out_data` hold stable.
- Counters:
  - There are ten CNT_W-bit counters.
  - On each input accept, the counter of the decoded class increments.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
- `cnt_clr` behaviour:
  - Zeroes all counters on the next edge.
  - `cnt_clr` and an accept in the same cycle: clear wins, and the accepted operand is not counted.
  - `cnt_clr` does not affect the pipeline.
- `cnt_data` is a combinational mux of the counter registers.

## Timing
- Latency: operand accepted at edge N appears on `out_*` after edge N, i.e. one cycle.
- Throughput: one operand per cycle while `out_ready` = 1.
- Reset values:
  - `out_valid` = 0.
  - `out_class` = 0.
  - `out_data` = 0.
  - All counters = 0.
  - `in_ready` = 1 in the cycle after reset deasserts.
- Reset mid-operation: a pending result is discarded and is not delivered.
- During `rst` = 1, the handshake is ignored and no counters change.
- Input stability: `in_data` needs to be stable only in the accept cycle.
- No combinational path from `in_valid` to `out_*`. The only combinational in-to-out path is `out_ready` → `in_ready`.

## Structure
- `fp_class_pkg` holds:
  - Class index localparams: `CLS_NINF` … `CLS_QNAN`, 0–9.
  - `NUM_CLASSES = 10`.
  - A function computing `FP_W` from `EXP_W`/`MAN_W`.
- Sub-module `fp_class_decode` (parametrised EXP_W, MAN_W): purely combinational field decode producing the 10-bit one-hot vector. It is reusable by the FPU's other units.
- Top level holds only:
  - The handshake register.
  - The counter array with saturate/clear logic.
  - The readback mux.

## Test plan
- Default params, `out_ready` = 1. Stream 0xFC00, 0xBC00, 0x8001, 0x8000, 0x0000, 0x0001, 0x3C00, 0x7C00, 0x7C01, 0x7E00 → `out_class` one-hot bits 0..9 in order, each one cycle after accept, `out_data` echoing the operand.
- EXP_W=8, MAN_W=23: 0x7F800000 → bit 7; 0x7FC00000 → bit 9; 0xFF800001 → bit 8; 0x00400000 → bit 5.
- Backpressure: hold `out_ready` = 0 for 3 cycles after accepting 0x3C00 → `in_ready` = 0, and `out_class` = 0x040 held stable. Then raise `out_ready` with `in_valid` = 1 carrying 0x7C00 → same-cycle accept, next output 0x080, no bubble.
- Counters, CNT_W=2: accept 5× 0x0000 → `cnt_data` at `cnt_sel` = 4 reads 3 (saturated). Then assert `cnt_clr` together with an accept of 0x0000 → counter reads 0. `cnt_sel` = 12 → 0.
- Reset mid-operation: `out_valid` = 1 holding 0x7E00 with `out_ready` = 0. Assert `rst` for 1 cycle → `out_valid` = 0, `out_class` = 0, all counters 0, `in_ready` = 1.
